// File: rtl/i2s_lock_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_lock_monitor                                                           |
// | Registers the I2S bus toward i2s_to_pcm, measures BCK per LRCK half-frame, |
// | and mutes DATAOUT until a run of consistent symmetric frames is seen.      |
// | Optional stall timeout: define I2S_LOCK_MONITOR_TIMEOUT_EN.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module i2s_lock_monitor #(
  parameter int LOCK_FRAMES = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 128
) (
  input  logic       BCK,
  input  logic       RESETN,
  input  logic       LRCK,
  input  logic       DATAIN,
  output logic       LRCKOUT,
  output logic       DATAOUT,
  output logic       LOCKED,
  output logic [1:0] FS_CODE
);

  localparam int               c_GOOD_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

`ifdef I2S_LOCK_MONITOR_TIMEOUT_EN
  localparam bit c_TIMEOUT_EN = 1'b1;
`else
  localparam bit c_TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_CHECK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, r_ref, w_ref_nxt, w_meas;
  logic [c_GOOD_W-1:0] r_good_cnt, w_good_nxt;
  logic [1:0]          r_fs_code, w_fs_nxt;
  logic                r_lrck_d, r_gate, r_dataout, w_gate_nxt;
  logic                w_rise, w_fall, w_edge, w_allowed, w_match, w_timeout;

  function automatic logic [1:0] fs_of(input logic [CNT_W-1:0] len);
    if (len == CNT_W'(16)) return 2'b01;
    if (len == CNT_W'(24)) return 2'b10;
    if (len == CNT_W'(32)) return 2'b11;
    return 2'b00;
  endfunction

  assign w_rise    = LRCK & ~r_lrck_d;
  assign w_fall    = ~LRCK & r_lrck_d;
  assign w_edge    = w_rise | w_fall;
  assign w_meas    = r_cnt;
  assign w_allowed = (w_meas == CNT_W'(16)) || (w_meas == CNT_W'(24)) || (w_meas == CNT_W'(32));
  assign w_match   = (w_meas == r_ref);
  assign w_timeout = c_TIMEOUT_EN && (r_state != S_SEARCH) && !w_edge && (int'(r_cnt) >= TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_ref_nxt   = r_ref;
    case (r_state)
      S_SEARCH: begin
        if (w_fall) begin
          w_state_nxt = S_CHECK;
          w_good_nxt  = '0;
        end
      end
      S_CHECK: begin
        if (w_rise) begin
          // The first left half of a run defines the reference length.
          if (!w_allowed || ((r_good_cnt != '0) && !w_match))
            w_state_nxt = S_SEARCH;
          else if (r_good_cnt == '0)
            w_ref_nxt = w_meas;
        end else if (w_fall) begin
          if (w_match) begin
            w_good_nxt = r_good_cnt + 1'b1;
            if (r_good_cnt == c_GOOD_W'(LOCK_FRAMES - 1))
              w_state_nxt = S_LOCKED;
          end else begin
            w_good_nxt = '0;
          end
        end
      end
      S_LOCKED: begin
        if (w_edge && !w_match) begin
          w_state_nxt = w_rise ? S_SEARCH : S_CHECK;
          w_good_nxt  = '0;
        end
      end
      default: w_state_nxt = S_SEARCH;
    endcase
    if (w_timeout) w_state_nxt = S_SEARCH;
  end

  assign w_gate_nxt = (w_state_nxt == S_LOCKED);
  assign w_fs_nxt   = w_gate_nxt ? fs_of(w_ref_nxt) : 2'b00;

  always_ff @(posedge BCK or negedge RESETN) begin
    if (!RESETN) begin
      r_lrck_d   <= 1'b0;
      r_cnt      <= '0;
      r_ref      <= '0;
      r_good_cnt <= '0;
      r_state    <= S_SEARCH;
      r_gate     <= 1'b0;
      r_fs_code  <= 2'b00;
      r_dataout  <= 1'b0;
    end else begin
      r_lrck_d   <= LRCK;
      r_cnt      <= w_edge ? CNT_W'(1) : ((r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1);
      r_ref      <= w_ref_nxt;
      r_good_cnt <= w_good_nxt;
      r_state    <= w_state_nxt;
      r_gate     <= w_gate_nxt;
      r_fs_code  <= w_fs_nxt;
      // Old gate applies to the bit sampled on the edge cycle, so a word is never cut.
      r_dataout  <= DATAIN & r_gate;
    end
  end

  assign LRCKOUT = r_lrck_d;
  assign DATAOUT = r_dataout;
  assign LOCKED  = (r_state == S_LOCKED);
  assign FS_CODE = r_fs_code;

endmodule
`default_nettype wire

// File: tb/tb_i2s_lock_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2s_lock_monitor                                                        |
// | Directed I2S frames; expected outputs queued per BCK, checked by monitor.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_i2s_lock_monitor;

  logic       BCK, RESETN, LRCK, DATAIN;
  logic       LRCKOUT, DATAOUT, LOCKED;
  logic [1:0] FS_CODE;

  i2s_lock_monitor dut (
    .BCK     (BCK),
    .RESETN  (RESETN),
    .LRCK    (LRCK),
    .DATAIN  (DATAIN),
    .LRCKOUT (LRCKOUT),
    .DATAOUT (DATAOUT),
    .LOCKED  (LOCKED),
    .FS_CODE (FS_CODE)
  );

  typedef struct {
    int         cyc;
    logic [4:0] val;  // {LRCKOUT, DATAOUT, LOCKED, FS_CODE}
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [4:0] mon_act;
  int         cyc       = 0;
  int         n_chk     = 0;
  int         n_pass    = 0;
  int         n_fail    = 0;
  int         n_word    = 0;
  logic       prev_lsb  = 1'b0;
  logic       prev_lock = 1'b0;
  logic       in_rst    = 1'b1;

  initial BCK = 1'b0;
  always #5 BCK = ~BCK;
  always @(posedge BCK) cyc <= cyc + 1;

  // One BCK of stimulus; the response is expected on the following rising edge.
  task automatic tick(input logic lr, input logic d, input logic lk, input logic [1:0] fs);
    exp_t e;
    @(negedge BCK);
    LRCK   = lr;
    DATAIN = d;
    e.cyc  = cyc + 1;
    if (in_rst) e.val = 5'b0;
    else        e.val = {lr, d & prev_lock, lk, lk ? fs : 2'b00};
    prev_lock = in_rst ? 1'b0 : lk;
    q.push_back(e);
  endtask

  // I2S half-frame: slot 0 carries the previous word's LSB, then MSB first.
  task automatic half(input logic lr, input int len, input logic [31:0] word,
                      input logic lk, input logic [1:0] fs, input int unlock_at);
    for (int i = 0; i < len; i++) begin
      logic b;
      int   idx;
      idx = len - i;
      if (i == 0) b = prev_lsb;
      else        b = (idx < 32) ? word[idx] : 1'b0;
      tick(lr, b, ((unlock_at >= 0) && (i >= unlock_at)) ? 1'b0 : lk, fs);
    end
    prev_lsb = word[0];
  endtask

  task automatic frame(input int ll, input int rl, input logic lkl, input logic lkr,
                       input logic [1:0] fs);
    half(1'b0, ll, 32'h00A5A5A5 + n_word, lkl, fs, -1);
    half(1'b1, rl, 32'h005A5A5A + n_word, lkr, fs, -1);
    n_word++;
  endtask

  task automatic frames(input int n, input int ll, input int rl, input logic lk,
                        input logic [1:0] fs);
    for (int i = 0; i < n; i++) frame(ll, rl, lk, lk, fs);
  endtask

  initial begin
    RESETN = 1'b0;
    LRCK   = 1'b0;
    DATAIN = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge BCK); #2;
    RESETN = 1'b1;
    in_rst = 1'b0;

    // Partial half discarded, four good 24-BCK frames, lock at the next fall.
    half(1'b1, 10, 32'h0, 1'b0, 2'b00, -1);
    frames(4, 24, 24, 1'b0, 2'b00);
    frames(2, 24, 24, 1'b1, 2'b10);

    // Short right half drops lock at its closing fall, then a full re-lock.
    frame(24, 23, 1'b1, 1'b1, 2'b10);
    frames(4, 24, 24, 1'b0, 2'b00);
    frames(1, 24, 24, 1'b1, 2'b10);

    // Format change to 32, then to 16.
    frame(32, 32, 1'b1, 1'b0, 2'b10);
    frames(4, 32, 32, 1'b0, 2'b00);
    frames(1, 32, 32, 1'b1, 2'b11);
    frame(16, 16, 1'b1, 1'b0, 2'b11);
    frames(4, 16, 16, 1'b0, 2'b00);
    frames(1, 16, 16, 1'b1, 2'b01);

    // Reset for 3 BCK mid left word; outputs clear before the next rising edge.
    half(1'b0, 8, 32'h000000A5, 1'b1, 2'b01, -1);
    in_rst = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 2'b00);
    @(posedge BCK); #2;
    RESETN = 1'b0;
    repeat (3) tick(1'b0, 1'b1, 1'b0, 2'b00);
    @(posedge BCK); #2;
    RESETN = 1'b1;
    in_rst = 1'b0;
    half(1'b0, 5, 32'h0, 1'b0, 2'b00, -1);
    half(1'b1, 16, 32'h00005A5A, 1'b0, 2'b00, -1);
    frames(4, 16, 16, 1'b0, 2'b00);
    frames(1, 16, 16, 1'b1, 2'b01);

    // Asymmetric halves never lock.
    frame(24, 32, 1'b1, 1'b0, 2'b01);
    frames(9, 24, 32, 1'b0, 2'b00);

    // Re-lock at 24, then stall LRCK low well past counter saturation.
    frames(4, 24, 24, 1'b0, 2'b00);
    frames(1, 24, 24, 1'b1, 2'b10);
`ifdef I2S_LOCK_MONITOR_TIMEOUT_EN
    half(1'b0, 300, 32'h00C3C3C3, 1'b1, 2'b10, 128);
`else
    half(1'b0, 300, 32'h00C3C3C3, 1'b1, 2'b10, -1);
`endif
    half(1'b1, 24, 32'h003C3C3C, 1'b0, 2'b00, -1);

    for (int i = 0; (i < 20) && (q.size() > 0); i++) @(negedge BCK);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    forever begin
      @(negedge BCK);
      if ((q.size() > 0) && (q[0].cyc == cyc)) begin
        mon_e   = q.pop_front();
        mon_act = {LRCKOUT, DATAOUT, LOCKED, FS_CODE};
        n_chk++;
        if (mon_act === mon_e.val) n_pass++;
        else begin
          n_fail++;
          $display("FAIL outputs cyc=%0d {lrckout,dataout,locked,fs} got=%b want=%b",
                   cyc, mon_act, mon_e.val);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
